osd_dii_router: RTL and testbench
=================================

# osd_dii_router

Per-module ring router on the debug interconnect. It sits between the debug ring and one debug module such as the subnet control module. It steers incoming ring packets addressed to the local module ID onto the module's `debug_in`, and forwards all other ring packets downstream. It merges the module's own `debug_out` packets onto the outgoing ring with packet-atomic round-robin arbitration. All outputs are registered; neither output ever interleaves flits of two packets.

## Interface
Parameters:
- (none; ID is a port)

Ports (each `dii_channel` carries `data[15:0]`, `last`, `valid`, `ready`):
- clk  in  1  clock; single clock domain.
- rst  in  1  reset, asynchronous, active-high.
- id  in  10  local module address, compared with `data[9:0]` of the first flit.
- ring_in  dii_channel (sink)  16+3  packets arriving from the upstream ring.
- ring_out  dii_channel (source)  16+3  packets leaving to the downstream ring.
- local_in  dii_channel (sink)  16+3  packets from the module's `debug_out`.
- local_out  dii_channel (source)  16+3  packets to the module's `debug_in`.
- pkt_cnt  out  16  count of packets delivered on `local_out` (see Configuration).

## Operation
- Flit transfer: a flit moves when `valid && ready` are both high on a rising clk edge. A packet is every flit up to and including the flit with `last=1`. Flit 0 is the destination.
- **Ring input FSM: `R_IDLE`, `R_LOCAL`, `R_FWD`.**
  - In `R_IDLE`, the head flit routes to local if `data[9:0]==id`, otherwise to forward. The decision is combinational on the head flit.
  - On accepting the head flit with `last=0`, the FSM moves to `R_LOCAL` or `R_FWD`. With `last=1` it stays in `R_IDLE` (single-flit packet).
  - In `R_LOCAL` or `R_FWD`, the FSM holds the route until the flit with `last=1` is accepted, then returns to `R_IDLE`.
  - Bits [15:10] of the head flit are ignored.
- **`local_in` routing:** always goes to `ring_out`. It never loops back, even when the destination equals `id`.
- **ring_out arbiter: `A_IDLE`, `A_RING`, `A_LOCAL`.** Requesters are `ring_in` (routed forward) and `local_in`.
  - In `A_IDLE` with one requester, that requester is granted.
  - In `A_IDLE` with both requesting, grant goes to the one not granted most recently. After reset, `ring_in` wins.
  - The grant is taken on the head-flit transfer. It is held until the `last` flit transfers, then the arbiter returns to `A_IDLE`.
  - A single-flit packet grants and releases in the same cycle; the history bit still updates.
- **Output stages:** each output is a 1-entry register (`valid`, `data`, `last`).
  - The slot is free when `!valid || ready`.
  - `ring_in.ready`: slot-free of `local_out` when routed local; slot-free of `ring_out` AND arbiter grant (or granting) to ring when routed forward.
  - `local_in.ready`: slot-free of `ring_out` AND grant (or granting) to local.
- **Head-of-line blocking:** a stalled `local_out` stalls `ring_in` entirely. This is accepted behaviour.

## Timing
- Reset values: `ring_out.valid=0`, `local_out.valid=0`, `ring_in.ready=0`, `local_in.ready=0`, `pkt_cnt=0`. Data and last outputs are 0. FSMs go to `R_IDLE` and `A_IDLE`, and the history bit favours ring.
- A reset asserted mid-packet discards all partial packets. No recovery flits are emitted.
- Latency: a flit accepted at edge N is valid on its output after edge N, i.e. 1 cycle.
- Throughput: 1 flit/cycle per output when the downstream `ready` stays high. Input `ready` depends combinationally on output `ready`.
- Simultaneous events: a `ring_in` local delivery and a `local_in` transfer to `ring_out` may occur in the same cycle.
- Once asserted, output `valid` is never withdrawn until accepted, and its data stays stable.

## Configuration
- `OSD_DII_ROUTER_PKTCNT_EN` defined: `pkt_cnt` increments by 1 on each `local_out` transfer with `last=1`. It wraps from 0xFFFF to 0x0000.
- Not defined: `pkt_cnt` is tied to 0 and no counter flops exist.

## Test plan
- **Local delivery:** `id`=0x005; `ring_in` sends 3 flits 0x0005, 0x0001, 0xABCD (last on the third) with outputs ready. Required: `local_out` shows the same 3 flits at cycles +1..+3, `ring_out.valid` stays 0, and `pkt_cnt`=1 (macro on).
- **Forward:** the same packet with head 0x0007. Required: it appears only on `ring_out`, and `local_out.valid` stays 0.
- **Arbitration:** after reset, `ring_in` (head 0x0009, 4 flits) and `local_in` (3 flits) both become valid in the same cycle. Required: `ring_out` carries the 4 ring flits, then the 3 local flits, with no interleaving. A following simultaneous request is granted to `local_in` first only if ring was granted last; here ring was granted last, so local wins.
- **Back-pressure:** `local_out.ready=0` while a local packet arrives. Required: `local_out` holds flit 0 stable, `ring_in.ready=0` on the next flit, and no flit is lost once ready returns to 1.
- **Reset mid-packet:** assert `rst` after flit 2 of a 4-flit forwarded packet. Required: all valid and ready outputs are 0 immediately, and a new packet with head 0x0005 after reset is routed local.
- **Counter wrap:** with the macro on, deliver 65536 single-flit local packets. Required: `pkt_cnt` returns to 0x0000.

Source files
------------

// File: rtl/osd_dii_router.sv
// Debug-ring router: steers ring packets for `id` to local_out, forwards the rest,
// and merges local_in onto ring_out with packet-atomic round-robin arbitration.
// Optional packet counter on local_out enabled by OSD_DII_ROUTER_PKTCNT_EN.
//
// ring FSM  state   | meaning
//           R_IDLE  | waiting for a head flit; route decided from its data[9:0]
//           R_LOCAL | mid-packet, flits go to local_out
//           R_FWD   | mid-packet, flits go to ring_out
// arbiter   A_IDLE  | ring_out free; head flit of either requester may be granted
//           A_RING  | ring_out owned by a forwarded ring_in packet
//           A_LOCAL | ring_out owned by a local_in packet
module osd_dii_router (
    input  logic        clk,
    input  logic        rst,
    input  logic [9:0]  id,

    input  logic [15:0] ring_in_data,
    input  logic        ring_in_last,
    input  logic        ring_in_valid,
    output logic        ring_in_ready,

    output logic [15:0] ring_out_data,
    output logic        ring_out_last,
    output logic        ring_out_valid,
    input  logic        ring_out_ready,

    input  logic [15:0] local_in_data,
    input  logic        local_in_last,
    input  logic        local_in_valid,
    output logic        local_in_ready,

    output logic [15:0] local_out_data,
    output logic        local_out_last,
    output logic        local_out_valid,
    input  logic        local_out_ready,

    output logic [15:0] pkt_cnt
);

    typedef enum logic [1:0] {R_IDLE, R_LOCAL, R_FWD} ring_state_t;
    typedef enum logic [1:0] {A_IDLE, A_RING, A_LOCAL} arb_state_t;

    ring_state_t ring_state, ring_state_nxt;
    arb_state_t  arb_state, arb_state_nxt;
    logic        prio_ring, prio_ring_nxt;

    logic route_local;
    logic ro_free, lo_free;
    logic ring_req, local_req;
    logic grant_ring, grant_local;
    logic ring_fire, local_fire, ring_fwd_fire, ring_loc_fire;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ring_state <= R_IDLE;
            arb_state  <= A_IDLE;
            prio_ring  <= 1'b1;
        end else begin
            ring_state <= ring_state_nxt;
            arb_state  <= arb_state_nxt;
            prio_ring  <= prio_ring_nxt;
        end
    end

    always_comb begin
        ro_free = !ring_out_valid || ring_out_ready;
        lo_free = !local_out_valid || local_out_ready;

        case (ring_state)
            R_LOCAL: route_local = 1'b1;
            R_FWD:   route_local = 1'b0;
            default: route_local = (ring_in_data[9:0] == id);
        endcase

        ring_req  = ring_in_valid && !route_local;
        local_req = local_in_valid;

        grant_ring  = 1'b0;
        grant_local = 1'b0;
        case (arb_state)
            A_RING:  grant_ring  = 1'b1;
            A_LOCAL: grant_local = 1'b1;
            default: begin
                if (ring_req && (!local_req || prio_ring))
                    grant_ring = 1'b1;
                else if (local_req)
                    grant_local = 1'b1;
            end
        endcase

        // Readies are forced low while reset is held so nothing is accepted.
        ring_in_ready  = !rst && (route_local ? lo_free : (ro_free && grant_ring));
        local_in_ready = !rst && ro_free && grant_local;

        ring_fire     = ring_in_valid && ring_in_ready;
        local_fire    = local_in_valid && local_in_ready;
        ring_fwd_fire = ring_fire && !route_local;
        ring_loc_fire = ring_fire && route_local;
    end

    always_comb begin
        ring_state_nxt = ring_state;
        if (ring_fire) begin
            if (ring_in_last)
                ring_state_nxt = R_IDLE;
            else
                ring_state_nxt = route_local ? R_LOCAL : R_FWD;
        end
    end

    // History bit only moves when a new packet is granted from A_IDLE.
    always_comb begin
        arb_state_nxt = arb_state;
        prio_ring_nxt = prio_ring;
        if (ring_fwd_fire) begin
            arb_state_nxt = ring_in_last ? A_IDLE : A_RING;
            if (arb_state == A_IDLE)
                prio_ring_nxt = 1'b0;
        end else if (local_fire) begin
            arb_state_nxt = local_in_last ? A_IDLE : A_LOCAL;
            if (arb_state == A_IDLE)
                prio_ring_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ring_out_valid <= 1'b0;
            ring_out_data  <= '0;
            ring_out_last  <= 1'b0;
        end else if (ring_fwd_fire) begin
            ring_out_valid <= 1'b1;
            ring_out_data  <= ring_in_data;
            ring_out_last  <= ring_in_last;
        end else if (local_fire) begin
            ring_out_valid <= 1'b1;
            ring_out_data  <= local_in_data;
            ring_out_last  <= local_in_last;
        end else if (ring_out_ready) begin
            ring_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            local_out_valid <= 1'b0;
            local_out_data  <= '0;
            local_out_last  <= 1'b0;
        end else if (ring_loc_fire) begin
            local_out_valid <= 1'b1;
            local_out_data  <= ring_in_data;
            local_out_last  <= ring_in_last;
        end else if (local_out_ready) begin
            local_out_valid <= 1'b0;
        end
    end

`ifdef OSD_DII_ROUTER_PKTCNT_EN
    logic [15:0] pkt_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pkt_cnt_q <= '0;
        else if (local_out_valid && local_out_ready && local_out_last)
            pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end

    assign pkt_cnt = pkt_cnt_q;
`else
    assign pkt_cnt = '0;
`endif

endmodule

// File: tb/tb_osd_dii_router.sv
// Self-checking bench for osd_dii_router: directed scenarios plus randomized traffic
// checked against a queue-based packet model.
module tb_osd_dii_router;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  id;
    logic [15:0] ring_in_data, ring_out_data, local_in_data, local_out_data;
    logic        ring_in_last, ring_in_valid, ring_in_ready;
    logic        ring_out_last, ring_out_valid, ring_out_ready;
    logic        local_in_last, local_in_valid, local_in_ready;
    logic        local_out_last, local_out_valid, local_out_ready;
    logic [15:0] pkt_cnt;

    osd_dii_router dut (
        .clk(clk), .rst(rst), .id(id),
        .ring_in_data(ring_in_data), .ring_in_last(ring_in_last),
        .ring_in_valid(ring_in_valid), .ring_in_ready(ring_in_ready),
        .ring_out_data(ring_out_data), .ring_out_last(ring_out_last),
        .ring_out_valid(ring_out_valid), .ring_out_ready(ring_out_ready),
        .local_in_data(local_in_data), .local_in_last(local_in_last),
        .local_in_valid(local_in_valid), .local_in_ready(local_in_ready),
        .local_out_data(local_out_data), .local_out_last(local_out_last),
        .local_out_valid(local_out_valid), .local_out_ready(local_out_ready),
        .pkt_cnt(pkt_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet model: every flit accepted towards an output is queued in order;
    // output transfers must pop them back unchanged.
    logic [16:0] ro_q[$], lo_q[$];
    logic [15:0] ro_log[$], lo_log[$], exp_q[$];
    bit          ring_mid, ring_dest_local;
    int          ro_src;
    logic [15:0] cnt_m;

    logic [9:0]  p_id;
    bit          p_rst, p_rin_f, p_rin_l, p_lin_f, p_lin_l;
    bit          p_ro_v, p_ro_r, p_ro_l, p_lo_v, p_lo_r, p_lo_l;
    logic [15:0] p_rin_d, p_lin_d, p_ro_d, p_lo_d;
    bit          ro_push, lo_push;
    logic [16:0] ro_new, lo_new, exp_f;

    task automatic note_src(input int s, input bit l);
        if (ro_src != 0)
            check_eq("ring_out_interleave", s, ro_src);
        ro_src = l ? 0 : s;
    endtask

    always begin : monitor
        @(negedge clk); #1;
        p_rst   = rst;
        p_id    = id;
        p_rin_f = ring_in_valid && ring_in_ready;
        p_rin_d = ring_in_data;   p_rin_l = ring_in_last;
        p_lin_f = local_in_valid && local_in_ready;
        p_lin_d = local_in_data;  p_lin_l = local_in_last;
        p_ro_v  = ring_out_valid; p_ro_r = ring_out_ready;
        p_ro_d  = ring_out_data;  p_ro_l = ring_out_last;
        p_lo_v  = local_out_valid; p_lo_r = local_out_ready;
        p_lo_d  = local_out_data;  p_lo_l = local_out_last;
        if (p_rst) begin
            check_eq("reset_valid_ready",
                     {ring_out_valid, local_out_valid, ring_in_ready, local_in_ready}, 0);
            check_eq("reset_pkt_cnt", pkt_cnt, 0);
        end
        @(posedge clk); #1;
        if (p_rst) begin
            ro_q.delete();
            lo_q.delete();
            ring_mid = 0;
            ro_src   = 0;
            cnt_m    = 0;
        end else begin
            if (p_ro_v && p_ro_r) begin
                ro_log.push_back(p_ro_d);
                check_eq("ring_out_unexpected", ro_q.size() > 0, 1);
                if (ro_q.size() > 0) begin
                    exp_f = ro_q.pop_front();
                    check_eq("ring_out_flit", {p_ro_l, p_ro_d}, exp_f);
                end
            end
            if (p_lo_v && p_lo_r) begin
                lo_log.push_back(p_lo_d);
                check_eq("local_out_unexpected", lo_q.size() > 0, 1);
                if (lo_q.size() > 0) begin
                    exp_f = lo_q.pop_front();
                    check_eq("local_out_flit", {p_lo_l, p_lo_d}, exp_f);
                end
                if (p_lo_l)
                    cnt_m = cnt_m + 16'd1;
            end
            if (p_ro_v && !p_ro_r)
                check_eq("ring_out_hold", {ring_out_valid, ring_out_last, ring_out_data},
                         {1'b1, p_ro_l, p_ro_d});
            if (p_lo_v && !p_lo_r)
                check_eq("local_out_hold", {local_out_valid, local_out_last, local_out_data},
                         {1'b1, p_lo_l, p_lo_d});

            ro_push = 0;
            lo_push = 0;
            if (p_rin_f) begin
                if (!ring_mid)
                    ring_dest_local = (p_rin_d[9:0] == p_id);
                ring_mid = !p_rin_l;
                if (ring_dest_local) begin
                    lo_push = 1;
                    lo_new  = {p_rin_l, p_rin_d};
                end else begin
                    ro_push = 1;
                    ro_new  = {p_rin_l, p_rin_d};
                    note_src(1, p_rin_l);
                end
            end
            if (p_lin_f) begin
                check_eq("ring_out_collision", ro_push, 0);
                ro_push = 1;
                ro_new  = {p_lin_l, p_lin_d};
                note_src(2, p_lin_l);
            end
            if (ro_push) begin
                ro_q.push_back(ro_new);
                check_eq("ring_out_latency", {ring_out_valid, ring_out_last, ring_out_data},
                         {1'b1, ro_new});
            end else if (!(p_ro_v && !p_ro_r)) begin
                check_eq("ring_out_idle", ring_out_valid, 0);
            end
            if (lo_push) begin
                lo_q.push_back(lo_new);
                check_eq("local_out_latency", {local_out_valid, local_out_last, local_out_data},
                         {1'b1, lo_new});
            end else if (!(p_lo_v && !p_lo_r)) begin
                check_eq("local_out_idle", local_out_valid, 0);
            end
`ifdef OSD_DII_ROUTER_PKTCNT_EN
            check_eq("pkt_cnt", pkt_cnt, cnt_m);
`else
            check_eq("pkt_cnt_tied", pkt_cnt, 0);
`endif
        end
    end

    // Drivers: called at a falling edge, return at a falling edge.
    task automatic push_ring_flit(input logic [15:0] d, input bit l, output bit ok);
        int n = 0;
        ring_in_valid = 1'b1;
        ring_in_data  = d;
        ring_in_last  = l;
        #1;
        while (!ring_in_ready && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        ok = ring_in_ready;
        check_eq("ring_in_accept", ok, 1);
        @(negedge clk);
    endtask

    task automatic push_local_flit(input logic [15:0] d, input bit l, output bit ok);
        int n = 0;
        local_in_valid = 1'b1;
        local_in_data  = d;
        local_in_last  = l;
        #1;
        while (!local_in_ready && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        ok = local_in_ready;
        check_eq("local_in_accept", ok, 1);
        @(negedge clk);
    endtask

    logic [15:0] rpkt[$], lpkt[$];

    task automatic send_ring();
        bit ok;
        for (int i = 0; i < rpkt.size(); i++) begin
            push_ring_flit(rpkt[i], i == rpkt.size() - 1, ok);
            if (!ok) break;
        end
        ring_in_valid = 1'b0;
        ring_in_last  = 1'b0;
    endtask

    task automatic send_local();
        bit ok;
        for (int i = 0; i < lpkt.size(); i++) begin
            push_local_flit(lpkt[i], i == lpkt.size() - 1, ok);
            if (!ok) break;
        end
        local_in_valid = 1'b0;
        local_in_last  = 1'b0;
    endtask

    task automatic ring_rand_pkt();
        int len = $urandom_range(1, 4);
        bit ok;
        logic [15:0] d;
        ring_in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        for (int i = 0; i < len; i++) begin
            if (i > 0 && $urandom_range(0, 4) == 0) begin
                ring_in_valid = 1'b0;
                ring_in_data  = 16'($urandom);
                @(negedge clk);
            end
            d = 16'($urandom);
            if (i == 0 && $urandom_range(0, 9) < 4)
                d[9:0] = id;
            push_ring_flit(d, i == len - 1, ok);
            if (!ok) break;
        end
        ring_in_valid = 1'b0;
        ring_in_last  = 1'b0;
    endtask

    task automatic local_rand_pkt();
        int len = $urandom_range(1, 4);
        bit ok;
        logic [15:0] d;
        local_in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        for (int i = 0; i < len; i++) begin
            d = 16'($urandom);
            if (i == 0 && $urandom_range(0, 3) == 0)
                d[9:0] = id;
            push_local_flit(d, i == len - 1, ok);
            if (!ok) break;
        end
        local_in_valid = 1'b0;
        local_in_last  = 1'b0;
    endtask

    task automatic check_log(input string name, input logic [15:0] got[$], input logic [15:0] exp[$]);
        check_eq({name, "_len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check_eq(name, got[i], exp[i]);
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        ring_in_valid  = 1'b0;
        ring_in_last   = 1'b0;
        local_in_valid = 1'b0;
        local_in_last  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    bit rand_on;
    int acc, cyc;
    bit ok_f;

    initial begin
        rst             = 1'b1;
        id              = 10'h005;
        ring_in_valid   = 1'b1;
        ring_in_data    = 16'h0005;
        ring_in_last    = 1'b1;
        local_in_valid  = 1'b1;
        local_in_data   = 16'h0001;
        local_in_last   = 1'b1;
        ring_out_ready  = 1'b1;
        local_out_ready = 1'b1;
        @(negedge clk); #1;
        check_eq("rst_ring_out", {ring_out_valid, ring_out_last, ring_out_data}, 0);
        check_eq("rst_local_out", {local_out_valid, local_out_last, local_out_data}, 0);
        check_eq("rst_in_ready", {ring_in_ready, local_in_ready}, 0);
        check_eq("rst_pkt_cnt_init", pkt_cnt, 0);
        @(negedge clk);
        do_reset();

        // Local delivery
        ro_log.delete(); lo_log.delete();
        rpkt = '{16'h0005, 16'h0001, 16'hABCD};
        send_ring();
        repeat (3) @(negedge clk);
        exp_q = '{16'h0005, 16'h0001, 16'hABCD};
        check_log("t1_local_out", lo_log, exp_q);
        check_eq("t1_no_forward", ro_log.size(), 0);
`ifdef OSD_DII_ROUTER_PKTCNT_EN
        check_eq("t1_pkt_cnt", pkt_cnt, 1);
`endif

        // Forward
        ro_log.delete(); lo_log.delete();
        rpkt = '{16'h0007, 16'h0001, 16'hABCD};
        send_ring();
        repeat (3) @(negedge clk);
        exp_q = '{16'h0007, 16'h0001, 16'hABCD};
        check_log("t2_ring_out", ro_log, exp_q);
        check_eq("t2_no_local", lo_log.size(), 0);

        // Arbitration: ring wins after reset, then round-robin
        do_reset();
        ro_log.delete(); lo_log.delete();
        rpkt = '{16'h0009, 16'h0011, 16'h0012, 16'h0013};
        lpkt = '{16'h0020, 16'h0021, 16'h0022};
        fork
            send_ring();
            send_local();
        join
        repeat (3) @(negedge clk);
        exp_q = '{16'h0009, 16'h0011, 16'h0012, 16'h0013, 16'h0020, 16'h0021, 16'h0022};
        check_log("t3_arb_first", ro_log, exp_q);
        rpkt = '{16'h0009, 16'h0077};
        send_ring();
        repeat (2) @(negedge clk);
        ro_log.delete();
        rpkt = '{16'h0009, 16'h0051};
        lpkt = '{16'h0060, 16'h0061};
        fork
            send_ring();
            send_local();
        join
        repeat (3) @(negedge clk);
        exp_q = '{16'h0060, 16'h0061, 16'h0009, 16'h0051};
        check_log("t3_arb_second", ro_log, exp_q);

        // Back-pressure on local_out
        ro_log.delete(); lo_log.delete();
        local_out_ready = 1'b0;
        rpkt = '{16'h0005, 16'h00A1, 16'h00A2};
        fork
            send_ring();
            begin
                repeat (3) @(negedge clk);
                #1;
                check_eq("t4_hold_flit0", {local_out_valid, local_out_last, local_out_data},
                         {1'b1, 1'b0, 16'h0005});
                check_eq("t4_ring_in_stalled", ring_in_ready, 0);
                @(negedge clk);
                local_out_ready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        exp_q = '{16'h0005, 16'h00A1, 16'h00A2};
        check_log("t4_local_out", lo_log, exp_q);

        // Reset in the middle of a forwarded packet
        do_reset();
        push_ring_flit(16'h0007, 1'b0, ok_f);
        push_ring_flit(16'h0101, 1'b0, ok_f);
        rst            = 1'b1;
        ring_in_valid  = 1'b1;
        ring_in_data   = 16'h0102;
        local_in_valid = 1'b1;
        local_in_data  = 16'h0300;
        local_in_last  = 1'b1;
        #1;
        check_eq("t5_rst_valid", {ring_out_valid, local_out_valid}, 0);
        check_eq("t5_rst_ready", {ring_in_ready, local_in_ready}, 0);
        @(negedge clk);
        rst            = 1'b0;
        ring_in_valid  = 1'b0;
        local_in_valid = 1'b0;
        local_in_last  = 1'b0;
        ro_log.delete(); lo_log.delete();
        rpkt = '{16'h0005, 16'h0202};
        send_ring();
        repeat (3) @(negedge clk);
        exp_q = '{16'h0005, 16'h0202};
        check_log("t5_after_reset", lo_log, exp_q);
        check_eq("t5_no_forward", ro_log.size(), 0);

        // Randomized traffic
        id = 10'h2A5;
        rand_on = 1;
        fork
            begin
                fork
                    for (int p = 0; p < 150; p++) ring_rand_pkt();
                    for (int p = 0; p < 150; p++) local_rand_pkt();
                join
                rand_on = 0;
            end
            while (rand_on) begin
                @(negedge clk);
                if (rand_on) begin
                    ring_out_ready  = ($urandom_range(0, 3) != 0);
                    local_out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        ring_out_ready  = 1'b1;
        local_out_ready = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("rand_ring_out_drained", ro_q.size(), 0);
        check_eq("rand_local_out_drained", lo_q.size(), 0);

`ifdef OSD_DII_ROUTER_PKTCNT_EN
        // Counter wrap over 65536 single-flit local packets
        do_reset();
        id = 10'h005;
        acc = 0;
        cyc = 0;
        ring_in_valid = 1'b1;
        ring_in_data  = 16'h0005;
        ring_in_last  = 1'b1;
        while (acc < 65536 && cyc < 70000) begin
            #1;
            if (ring_in_ready) acc++;
            cyc++;
            @(negedge clk);
        end
        ring_in_valid = 1'b0;
        ring_in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("wrap_accepted", acc, 65536);
        check_eq("wrap_pkt_cnt", pkt_cnt, 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
